imem_loader: RTL

- Writer-side companion to the instruction memory: receives a program as a little-endian byte stream and writes it into IMEM as 32-bit words.
- Writes start at a word address base, one word per write strobe.
- Holds the CPU (cpu_hold) while loading.
- Sits between the host/UART byte receiver and the IMEM write port at boot/reload.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_byte_packer.sv | 35 +++
 rtl/imem_loader.sv | 116 +++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared IMEM definitions: loader FSM state encoding and IMEM geometry
// used by the loader, the IMEM itself and the fetch path.
package imem_loader_defs;

    localparam int IMEM_ADDR_WIDTH = 18;
    localparam int INST_BYTES      = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RECV  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles incoming bytes into one little-endian instruction word.
// Byte 0 lands in bits [7:0], byte 3 in bits [31:24]. 'full' flags the
// load that completes the word, so the caller can switch to WRITE on
// that same edge while 'word' already holds all four lanes.
module imem_byte_packer
    import imem_loader_defs::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic                    clear,
    input  logic [7:0]              data,
    output logic                    full,
    output logic [INST_BYTES*8-1:0] word
);

    logic [1:0] idx;

    assign full = load && (idx == 2'(INST_BYTES - 1));

    // Lane index counter and assembly register; clear wins over load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx  <= '0;
            word <= '0;
        end else if (clear) begin
            idx  <= '0;
            word <= '0;
        end else if (load) begin
            word[idx*8 +: 8] <= data;
            idx              <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Boot/reload loader: takes a little-endian byte stream from the host
// receiver and writes it into IMEM as 32-bit words starting at
// BASE_ADDR, holding the core while the load runs. DATA_WIDTH must be 32.
module imem_loader
    import imem_loader_defs::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_WIDTH,
    parameter int DATA_WIDTH = INST_BYTES * 8,
    parameter int BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   word_count,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  err
);

    // Words that fit between BASE_ADDR and the top of IMEM; anything larger
    // is rejected up front so the address counter can never wrap.
    localparam logic [ADDR_WIDTH:0]   LIMIT =
        (ADDR_WIDTH+1)'((64'd1 << ADDR_WIDTH) - 64'(BASE_ADDR));
    localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

    state_t              state;
    logic [ADDR_WIDTH:0] remaining;
    logic                hs;
    logic                full;
    logic                clear;

    assign hs       = rx_valid & rx_ready;
    // Buffer is emptied after every write and kept empty while idle, so a
    // new load always starts at lane 0.
    assign clear    = (state == S_WRITE) || (state == S_IDLE);
    assign cpu_hold = busy;

    imem_byte_packer u_pack (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (hs),
        .clear (clear),
        .data  (rx_data),
        .full  (full),
        .word  (mem_wdata)
    );

    // Load sequencer with registered handshake/strobe/status outputs.
    // mem_addr is only advanced when another word follows, so it keeps the
    // last written address after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            remaining <= '0;
            mem_addr  <= '0;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (word_count > LIMIT) begin
                            err <= 1'b1;
                        end else if (word_count == '0) begin
                            state <= S_DONE;
                            busy  <= 1'b1;
                        end else begin
                            remaining <= word_count;
                            mem_addr  <= BASE;
                            rx_ready  <= 1'b1;
                            busy      <= 1'b1;
                            state     <= S_RECV;
                        end
                    end
                end
                S_RECV: begin
                    if (full) begin
                        rx_ready <= 1'b0;
                        mem_we   <= 1'b1;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    remaining <= remaining - 1'b1;
                    if (remaining == (ADDR_WIDTH+1)'(1)) begin
                        state <= S_DONE;
                    end else begin
                        mem_addr <= mem_addr + 1'b1;
                        rx_ready <= 1'b1;
                        state    <= S_RECV;
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
